// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC start-channel decoder: FSM state encoding,
// group width of the ones counter and a constant-evaluable clog2.
package tdc_pkg;

  localparam int TDC_GROUP_W = 16;

  typedef enum logic {
    ARMED = 1'b0,
    HOLD  = 1'b1
  } tdc_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tdc_popcnt16.sv
// Combinational ones counter for one 16-tap group of the delay line.
module tdc_popcnt16
  import tdc_pkg::*;
(
  input  logic [TDC_GROUP_W-1:0] bits_in,
  output logic [4:0]             count
);

  // Sum the set taps of the group.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    count = '0;
    for (int i = 0; i < TDC_GROUP_W; i++) begin
      count = count + {4'b0000, bits_in[i]};
    end
  end

endmodule

// File: rtl/start_therm_decoder.sv
// Start-channel thermometer decoder: registers the delay-line snapshot,
// detects the first nonzero snapshot after a quiet period, and encodes it
// into a fine ones count tagged with the coarse count at detection.
// Optional build macro START_BUBBLE_FILTER_EN adds a 3-tap majority filter
// stage after the input register (latency 4 instead of 3).
module start_therm_decoder
  import tdc_pkg::*;
#(
  parameter  int NFF      = 176,
  parameter  int COARSE_W = 24,
  localparam int FINE_W   = clog2(NFF + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NFF-1:0]      snap_in,
  input  logic                clr_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FINE_W-1:0]   out_fine,
  output logic [COARSE_W-1:0] out_coarse,
  output logic                out_sat,
  output logic                ovf
);

  localparam int NGRP = NFF / TDC_GROUP_W;

  logic [NFF-1:0]             s0_q, s0_d;
  logic [NFF-1:0]             det_vec;
  logic [COARSE_W-1:0]        coarse_q, coarse_d;
  tdc_state_e                 state_q, state_d;
  logic                       hit;

  logic [NGRP-1:0][4:0]       grp_cnt;
  logic [NGRP-1:0][4:0]       grp_cnt_q, grp_cnt_d;
  logic [COARSE_W-1:0]        st1_coarse_q, st1_coarse_d;
  logic                       st1_sat_q, st1_sat_d;
  logic                       st1_valid_q, st1_valid_d;
  logic [FINE_W-1:0]          fine_sum;

  logic                       out_valid_q, out_valid_d;
  logic [FINE_W-1:0]          out_fine_q, out_fine_d;
  logic [COARSE_W-1:0]        out_coarse_q, out_coarse_d;
  logic                       out_sat_q, out_sat_d;
  logic                       ovf_q, ovf_d;

  assign s0_d     = snap_in;
  assign coarse_d = coarse_q + COARSE_W'(1);

`ifdef START_BUBBLE_FILTER_EN
  logic [NFF-1:0] s1_q, s1_d;
  logic [NFF+1:0] s0_ext;

  // Majority of each tap and its neighbours; below tap 0 reads 1, above the top reads 0.
  always_comb begin
    s0_ext = {1'b0, s0_q, 1'b1};
    s1_d   = '0;
    for (int i = 0; i < NFF; i++) begin
      s1_d[i] = (s0_ext[i] & s0_ext[i+1]) | (s0_ext[i] & s0_ext[i+2]) |
                (s0_ext[i+1] & s0_ext[i+2]);
    end
  end

  // Filter stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

  assign det_vec = s1_q;
`else
  assign det_vec = s0_q;
`endif

  // Hit detection: first nonzero snapshot while armed; re-arm on a zero snapshot.
  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (det_vec != '0) begin
          hit     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (det_vec == '0) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_pop
    tdc_popcnt16 u_popcnt (
      .bits_in (det_vec[g*TDC_GROUP_W +: TDC_GROUP_W]),
      .count   (grp_cnt[g])
    );
  end

  // Stage 1 launches only the hit snapshot; idle cycles keep the data and clear valid.
  always_comb begin
    grp_cnt_d    = grp_cnt_q;
    st1_coarse_d = st1_coarse_q;
    st1_sat_d    = st1_sat_q;
    st1_valid_d  = 1'b0;
    if (hit) begin
      grp_cnt_d    = grp_cnt;
      st1_coarse_d = coarse_q;
      st1_sat_d    = &det_vec;
      st1_valid_d  = 1'b1;
    end
  end

  // Stage 2 sums the group counts and feeds the held output register.
  always_comb begin
    fine_sum = '0;
    for (int g = 0; g < NGRP; g++) begin
      fine_sum = fine_sum + FINE_W'(grp_cnt_q[g]);
    end

    out_valid_d  = out_valid_q;
    out_fine_d   = out_fine_q;
    out_coarse_d = out_coarse_q;
    out_sat_d    = out_sat_q;
    ovf_d        = ovf_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (clr_ovf) ovf_d = 1'b0;

    if (st1_valid_q) begin
      if (out_valid_q && !out_ready) begin
        // Output still held: the new result is lost and the drop wins over a clear.
        ovf_d = 1'b1;
      end else begin
        out_valid_d  = 1'b1;
        out_fine_d   = fine_sum;
        out_coarse_d = st1_coarse_q;
        out_sat_d    = st1_sat_q;
      end
    end
  end

  // State, counter and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q         <= '0;
      coarse_q     <= '0;
      state_q      <= ARMED;
      // NOTE: the pipeline data registers are reset too, so nothing from
      // before reset can surface as a result afterwards.
      grp_cnt_q    <= '0;
      st1_coarse_q <= '0;
      st1_sat_q    <= 1'b0;
      st1_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_fine_q   <= '0;
      out_coarse_q <= '0;
      out_sat_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s0_q         <= s0_d;
      coarse_q     <= coarse_d;
      state_q      <= state_d;
      grp_cnt_q    <= grp_cnt_d;
      st1_coarse_q <= st1_coarse_d;
      st1_sat_q    <= st1_sat_d;
      st1_valid_q  <= st1_valid_d;
      out_valid_q  <= out_valid_d;
      out_fine_q   <= out_fine_d;
      out_coarse_q <= out_coarse_d;
      out_sat_q    <= out_sat_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_fine   = out_fine_q;
  assign out_coarse = out_coarse_q;
  assign out_sat    = out_sat_q;
  assign ovf        = ovf_q;

endmodule

// File: doc/start_therm_decoder.md
START_THERM_DECODER -- requirements
Module: start_therm_decoder

Interface
REQ-001 SHALL have parameter NFF, default 176, number of delay-line taps in the start snapshot; must be a multiple of 16.
REQ-002 SHALL have parameter COARSE_W, default 24, coarse timestamp width in bits.
REQ-003 SHALL define FINE_W = clog2(NFF+1), which is 8 at the default NFF.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port snap_in  input  NFF  registered thermometer snapshot from the start pipeline; bit 0 is the earliest tap.
REQ-007 SHALL have port clr_ovf  input  1  single-cycle pulse that clears ovf.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out_fine  output  FINE_W  ones count of the hit snapshot.
REQ-011 SHALL have port out_coarse  output  COARSE_W  coarse count at hit detection.
REQ-012 SHALL have port out_sat  output  1  hit snapshot was all ones.
REQ-013 SHALL have port ovf  output  1  sticky flag: a result was dropped.

Function
REQ-014 SHALL register snap_in into an internal register s0 every cycle.
REQ-015 SHALL run a free-running coarse counter of COARSE_W bits that increments every cycle and wraps from all ones to 0.
REQ-016 SHALL implement an FSM with two states:
- ARMED: a nonzero s0 is a hit; capture the coarse count and go to HOLD.
- HOLD: when s0 == 0, go to ARMED; nonzero s0 is ignored.
REQ-017 SHALL launch only the hit snapshot into the encoder; a zero snapshot in ARMED produces no result.
REQ-018 SHALL run a 2-stage encoder:
- Stage 1: one 5-bit ones count per 16-bit group.
- Stage 2: sum of the group counts, FINE_W bits.
REQ-019 SHALL carry the coarse value and the sat flag through the encoder in lockstep with a valid bit.
REQ-020 SHALL produce a result 3 clk cycles after snap_in is sampled: s0 +1, stage 1 +1, stage 2 into the output register +1.
REQ-021 SHALL set out_sat = 1 and out_fine = NFF when the hit snapshot is all ones.
REQ-022 SHALL hold out_valid and all out_* stable until a cycle with out_valid && out_ready.
REQ-023 SHALL load a new result on the cycle of acceptance, so there are no bubble cycles.
REQ-024 SHALL drop a new result that arrives while out_valid && !out_ready, keep the held output unchanged, and set ovf.
REQ-025 SHALL clear ovf on clr_ovf; if clr_ovf coincides with a new drop, ovf SHALL stay 1.
REQ-026 SHALL accept a hit whose coarse counter wraps between detection and output without error; the captured value SHALL be exact.

Reset
REQ-027 SHALL, while rst_n = 0, asynchronously force:
- s0, all encoder pipeline registers and valid bits, and the coarse counter to 0;
- the FSM to ARMED;
- out_valid, out_fine, out_coarse, out_sat and ovf to 0.
REQ-028 SHALL discard, on reset mid-operation, any result in flight; no result SHALL appear after rst_n is released unless a new hit occurs.

Configuration
REQ-029 SHALL support macro START_BUBBLE_FILTER_EN.
- Defined: insert a stage after s0. Each tap i becomes the majority of taps i-1, i, i+1; out-of-range neighbours read 1 at the low end and 0 at the high end. Hit detection and encoding SHALL use the filtered vector, and latency SHALL be 4 cycles.
- Undefined: no filter; latency is 3 cycles.

Structure
REQ-030 SHALL place the following in shared package tdc_pkg:
- FSM state enum {ARMED, HOLD};
- the clog2 function;
- constant TDC_GROUP_W = 16.
REQ-031 SHALL implement the 16-bit group ones counter as sub-module tdc_popcnt16, instantiated NFF/16 times.

Verification
REQ-032 SHALL cover: snap_in = 0 for 5 cycles, then the lowest 37 taps = 1 for 2 cycles, then 0; out_ready = 1 -> one result 3 cycles after the hit sample, with out_fine = 37, out_sat = 0, and out_coarse = the counter value at hit detection.
REQ-033 SHALL cover: snap_in all ones -> out_fine = 176, out_sat = 1.
REQ-034 SHALL cover: out_ready = 0 with two hits 10 cycles apart -> the first result is held, the second is dropped, ovf = 1; a clr_ovf pulse -> ovf = 0.
REQ-035 SHALL cover: snapshot stays nonzero for 20 cycles -> exactly one result; a second hit after a zero cycle -> a second result.
REQ-036 SHALL cover: rst_n pulsed low 1 cycle after a hit -> no out_valid; coarse restarts from 0.
REQ-037 SHALL cover, with START_BUBBLE_FILTER_EN defined: taps 0..39 = 1 except tap 20 = 0 -> out_fine = 40, latency 4 cycles.
